// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl
// Brief    : Big-endian byte-addressed data memory with a valid/ready request
//            handshake and a fixed response latency. Optional macro
//            DMEM_ALIGN_CHECK_EN rejects misaligned half/word accesses
//            (otherwise the address is forced to alignment).
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
  parameter int DEPTH_BYTES  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int         AW         = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [1:0] c_CNT_LOAD = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_mem [DEPTH_BYTES];
  logic [31:0] r_res_data, r_rsp_rdata;
  logic        r_res_err, r_rsp_err;

  logic          w_accept;
  logic [31:0]   w_addr;
  logic [2:0]    w_nbytes;
  logic [32:0]   w_last;
  logic          w_err;
  logic [AW-1:0] w_idx [4];
  logic [7:0]    w_b   [4];
  logic [31:0]   w_load, w_res_data;
`ifdef DMEM_ALIGN_CHECK_EN
  logic          w_misaligned;
`endif

  assign w_accept = req_valid && req_ready;

  // Range check runs on 33 bits so a near-4GiB address cannot wrap into range.
  always_comb begin
    w_addr   = req_addr;
    w_nbytes = 3'd1;
    if (req_size == 2'b01)      w_nbytes = 3'd2;
    else if (req_size == 2'b10) w_nbytes = 3'd4;
`ifdef DMEM_ALIGN_CHECK_EN
    w_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    if (req_size == 2'b01)      w_addr[0]   = 1'b0;
    else if (req_size == 2'b10) w_addr[1:0] = 2'b00;
`endif
    w_last = {1'b0, w_addr} + 33'(w_nbytes) - 33'd1;
    w_err  = (req_size == 2'b11) || (w_last >= 33'(DEPTH_BYTES));
`ifdef DMEM_ALIGN_CHECK_EN
    w_err  = w_err || w_misaligned;
`endif
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k] = w_addr[AW-1:0] + AW'(k);
      w_b[k]   = r_mem[w_idx[k]];
    end
    case (req_size)
      2'b00:   w_load = req_unsigned ? {24'd0, w_b[0]} : {{24{w_b[0][7]}}, w_b[0]};
      2'b01:   w_load = req_unsigned ? {16'd0, w_b[0], w_b[1]}
                                     : {{16{w_b[0][7]}}, w_b[0], w_b[1]};
      default: w_load = {w_b[0], w_b[1], w_b[2], w_b[3]};
    endcase
    w_res_data = (req_write || w_err) ? 32'd0 : w_load;
  end

  // Storage is intentionally not reset; stores commit on the accept edge.
  always_ff @(posedge clk) begin
    if (w_accept && req_write && !w_err) begin
      case (req_size)
        2'b00: r_mem[w_idx[0]] <= req_wdata[7:0];
        2'b01: begin
          r_mem[w_idx[0]] <= req_wdata[15:8];
          r_mem[w_idx[1]] <= req_wdata[7:0];
        end
        default: begin
          r_mem[w_idx[0]] <= req_wdata[31:24];
          r_mem[w_idx[1]] <= req_wdata[23:16];
          r_mem[w_idx[2]] <= req_wdata[15:8];
          r_mem[w_idx[3]] <= req_wdata[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_res_data  <= 32'd0;
      r_res_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_res_data <= w_res_data;
        r_res_err  <= w_err;
      end
      // Response outputs only change on entry to RESP so they hold otherwise.
      if (w_accept && (READ_LATENCY == 1)) begin
        r_rsp_rdata <= w_res_data;
        r_rsp_err   <= w_err;
      end else if ((r_state == S_WAIT) && (r_cnt == 2'd1)) begin
        r_rsp_rdata <= r_res_data;
        r_rsp_err   <= r_res_err;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = (r_state != S_WAIT);
    rsp_valid   = (r_state == S_RESP);
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt == 2'd1) w_state_nxt = S_RESP;
      end
      default: begin
        if (w_accept) begin
          if (READ_LATENCY > 1) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_CNT_LOAD;
          end else begin
            w_state_nxt = S_RESP;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_ctrl
// Brief    : Drives two instances (latency 1 and 3) with directed and random
//            accesses, checked against a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [1:0]  req_size  [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  logic [7:0]  mm [2][DEPTH];
  logic [31:0] last_rd [2];
  logic        last_err [2];
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .READ_LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // Reference model: big-endian byte array, applied at the accept point.
  task automatic model(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd);
    longint a, v;
    int n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a = longint'(addr);
`ifdef DMEM_ALIGN_CHECK_EN
    err = (sz == 2'd3) || (a % n != 0) || (a + n - 1 >= DEPTH);
`else
    a = a - a % n;
    err = (sz == 2'd3) || (a + n - 1 >= DEPTH);
`endif
    rd = 32'd0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < n; i++) mm[d][a + i] = 8'(wd >> (8 * (n - 1 - i)));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(mm[d][a + i]);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        rd = v[31:0];
      end
    end
  endtask

  task automatic txn(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] obs_rd, output logic obs_err);
    logic        exp_err;
    logic [31:0] exp_rd;
    int budget, lat;
    lat = (d == 0) ? 1 : 3;
    budget = 0;
    while (req_ready[d] !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20) chkb("ready_timeout", req_ready[d], 1'b1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_size[d] = sz;
    req_unsigned[d] = uns;
    req_addr[d] = addr;
    req_wdata[d] = wd;
    model(d, wr, sz, uns, addr, wd, exp_err, exp_rd);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    for (int k = 1; k < lat; k++) begin
      chkb("wait_rsp_valid", rsp_valid[d], 1'b0);
      chkb("wait_req_ready", req_ready[d], 1'b0);
      chkb("wait_busy", busy[d], 1'b1);
      @(negedge clk);
    end
    chkb("rsp_valid", rsp_valid[d], 1'b1);
    chkb("rsp_req_ready", req_ready[d], 1'b1);
    chkb("rsp_busy", busy[d], 1'b1);
    chkb("rsp_err", rsp_err[d], exp_err);
    chk("rsp_rdata", rsp_rdata[d], exp_rd);
    obs_rd = rsp_rdata[d];
    obs_err = rsp_err[d];
    last_rd[d] = exp_rd;
    last_err[d] = exp_err;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, wd;
    logic        er;
    int          r, sel;
    logic [1:0]  sz;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0;
      req_unsigned[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chkb("reset_rsp_valid", rsp_valid[d], 1'b0);
      chk("reset_rsp_rdata", rsp_rdata[d], 32'd0);
      chkb("reset_rsp_err", rsp_err[d], 1'b0);
      chkb("reset_req_ready", req_ready[d], 1'b1);
      chkb("reset_busy", busy[d], 1'b0);
    end

    // Latency 1: word, byte and halfword round trips
    txn(0, 1'b1, 2'd2, 1'b0, 32'd0, 32'h07FFDFF0, rd, er);
    txn(0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, rd, er);
    chk("lw0_value", rd, 32'h07FFDFF0);
    txn(0, 1'b1, 2'd0, 1'b0, 32'd5, 32'h000000F0, rd, er);
    txn(0, 1'b0, 2'd0, 1'b0, 32'd5, 32'd0, rd, er);
    chk("lb5_value", rd, 32'hFFFFFFF0);
    txn(0, 1'b0, 2'd0, 1'b1, 32'd5, 32'd0, rd, er);
    chk("lbu5_value", rd, 32'h000000F0);
    txn(0, 1'b1, 2'd1, 1'b0, 32'd6, 32'h00008001, rd, er);
    txn(0, 1'b0, 2'd1, 1'b0, 32'd6, 32'd0, rd, er);
    chk("lh6_value", rd, 32'hFFFF8001);
    txn(0, 1'b0, 2'd1, 1'b1, 32'd6, 32'd0, rd, er);
    chk("lhu6_value", rd, 32'h00008001);

    // Range, size and overflow errors
    txn(0, 1'b1, 2'd2, 1'b0, 32'd1020, 32'hCAFEF00D, rd, er);
    txn(0, 1'b1, 2'd2, 1'b0, 32'd1024, 32'h12345678, rd, er);
    chkb("sw1024_err", er, 1'b1);
    txn(0, 1'b1, 2'd2, 1'b0, 32'd1022, 32'h0BADBEEF, rd, er);
    txn(0, 1'b0, 2'd3, 1'b0, 32'd0, 32'd0, rd, er);
    chkb("size11_err", er, 1'b1);
    txn(0, 1'b0, 2'd1, 1'b0, 32'hFFFFFFFE, 32'd0, rd, er);
    chkb("overflow_err", er, 1'b1);
    txn(0, 1'b0, 2'd2, 1'b0, 32'd1020, 32'd0, rd, er);
    chkb("lw1020_err", er, 1'b0);

    // Misaligned word load
    txn(0, 1'b1, 2'd2, 1'b0, 32'd0, 32'h11223344, rd, er);
    txn(0, 1'b1, 2'd2, 1'b0, 32'd4, 32'h55667788, rd, er);
    txn(0, 1'b0, 2'd2, 1'b0, 32'd2, 32'd0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chkb("misalign_err", er, 1'b1);
    chk("misalign_rdata", rd, 32'd0);
`else
    chkb("misalign_err", er, 1'b0);
    chk("misalign_rdata", rd, 32'h11223344);
`endif

    // Latency 3: back-to-back loads
    txn(1, 1'b1, 2'd2, 1'b0, 32'd0, 32'h11223344, rd, er);
    txn(1, 1'b1, 2'd2, 1'b0, 32'd4, 32'h55667788, rd, er);
    txn(1, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, rd, er);
    chk("l3_lw0", rd, 32'h11223344);
    txn(1, 1'b0, 2'd2, 1'b0, 32'd4, 32'd0, rd, er);
    chk("l3_lw4", rd, 32'h55667788);

    // Reset during WAIT of an accepted store
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_size[1] = 2'd2;
    req_unsigned[1] = 1'b0; req_addr[1] = 32'd8; req_wdata[1] = 32'hAABBCCDD;
    model(1, 1'b1, 2'd2, 1'b0, 32'd8, 32'hAABBCCDD, er, rd);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chkb("rst_mid_rsp_valid", rsp_valid[1], 1'b0);
      chk("rst_mid_rdata", rsp_rdata[1], 32'd0);
      chkb("rst_mid_err", rsp_err[1], 1'b0);
      chkb("rst_mid_busy", busy[1], 1'b0);
      @(negedge clk);
    end
    txn(1, 1'b0, 2'd2, 1'b0, 32'd8, 32'd0, rd, er);
    chk("rst_store_kept", rd, 32'hAABBCCDD);

    // Random traffic on both instances over initialised regions
    for (int d = 0; d < 2; d++) begin
      for (int ad = 0; ad < 64; ad += 4) txn(d, 1'b1, 2'd2, 1'b0, 32'(ad), $urandom, rd, er);
      for (int ad = 984; ad < 1024; ad += 4) txn(d, 1'b1, 2'd2, 1'b0, 32'(ad), $urandom, rd, er);
      for (int t = 0; t < 80; t++) begin
        sel = $urandom_range(0, 9);
        if (sel < 5)      a = 32'($urandom_range(0, 60));
        else if (sel < 9) a = 32'($urandom_range(990, 1023));
        else              a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        r = $urandom_range(0, 9);
        sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        wd = $urandom;
        txn(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd, rd, er);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      chkb("idle_rsp_valid", rsp_valid[d], 1'b0);
      chkb("idle_busy", busy[d], 1'b0);
      chk("hold_rdata", rsp_rdata[d], last_rd[d]);
      chkb("hold_err", rsp_err[d], last_err[d]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
